// File: rtl/mic1_bbus_regfile.sv
// MIC-1 datapath register file.
// Drives the B bus from the one-hot decoder select, latches the C bus into
// the registers named by the C field, and owns the MAR/MDR/PC/MBR memory-port
// timing: each request is issued one cycle after the microinstruction asks for
// it, and the read/fetch data lands in MDR/MBR at the end of that cycle.
module mic1_bbus_regfile #(
  parameter int unsigned          DATA_W   = 32,
  parameter logic [DATA_W-1:0]    PC_INIT  = 32'h0000_0000,
  parameter logic [DATA_W-1:0]    SP_INIT  = 32'h0000_8000,
  parameter logic [DATA_W-1:0]    LV_INIT  = 32'h0000_8000,
  parameter logic [DATA_W-1:0]    CPP_INIT = 32'h0000_4000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [15:0]       b_sel,
  input  logic [8:0]        c_en,
  input  logic [DATA_W-1:0] c_bus,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic              mem_fetch,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [7:0]        ifetch_data,
  output logic [DATA_W-1:0] b_bus,
  output logic [DATA_W-1:0] h_out,
  output logic [7:0]        mbr_out,
  output logic [DATA_W-1:0] mar_addr,
  output logic [DATA_W-1:0] mdr_wdata,
  output logic [DATA_W-1:0] pc_addr,
  output logic              mem_rd_req,
  output logic              mem_wr_req,
  output logic              mem_fetch_req,
  output logic              sel_err,
  output logic              mem_err
);

  // C field bit positions
  localparam int unsigned C_MAR = 0;
  localparam int unsigned C_MDR = 1;
  localparam int unsigned C_PC  = 2;
  localparam int unsigned C_SP  = 3;
  localparam int unsigned C_LV  = 4;
  localparam int unsigned C_CPP = 5;
  localparam int unsigned C_TOS = 6;
  localparam int unsigned C_OPC = 7;
  localparam int unsigned C_H   = 8;

  localparam logic [DATA_W-1:0] ZERO_W = {DATA_W{1'b0}};

  // Architectural registers
  logic [DATA_W-1:0] h_r;
  logic [DATA_W-1:0] opc_r;
  logic [DATA_W-1:0] tos_r;
  logic [DATA_W-1:0] cpp_r;
  logic [DATA_W-1:0] lv_r;
  logic [DATA_W-1:0] sp_r;
  logic [DATA_W-1:0] pc_r;
  logic [DATA_W-1:0] mdr_r;
  logic [DATA_W-1:0] mar_r;
  logic [7:0]        mbr_r;

  // One-deep request/load pipeline flags
  logic rd_pend_r;
  logic wr_req_r;
  logic fetch_pend_r;
  logic mem_err_r;

  // Request qualification: a simultaneous read and write is an error and
  // neither data request issues; fetch is independent of both.
  logic rd_ok_s;
  logic wr_ok_s;
  logic rw_err_s;

  assign rw_err_s = mem_rd & mem_wr;
  assign rd_ok_s  = mem_rd & ~mem_wr;
  assign wr_ok_s  = mem_wr & ~mem_rd;

  // B select validity: exactly one of bits 0-8 set and none of bits 9-15.
  logic [8:0] sel_low_s;
  logic       sel_onehot_s;
  logic       sel_valid_s;
  logic [DATA_W-1:0] b_bus_s;

  assign sel_low_s    = b_sel[8:0];
  assign sel_onehot_s = (sel_low_s != 9'd0) &&
                        ((sel_low_s & (sel_low_s - 9'd1)) == 9'd0);
  assign sel_valid_s  = sel_onehot_s && (b_sel[15:9] == 7'd0);

  // B bus source multiplexer; invalid selects drive zero.
  always_comb begin
    b_bus_s = ZERO_W;
    if (sel_valid_s) begin
      case (sel_low_s)
        9'h001:  b_bus_s = mdr_r;
        9'h002:  b_bus_s = pc_r;
        9'h004:  b_bus_s = {{(DATA_W-8){mbr_r[7]}}, mbr_r};
        9'h008:  b_bus_s = {{(DATA_W-8){1'b0}}, mbr_r};
        9'h010:  b_bus_s = sp_r;
        9'h020:  b_bus_s = lv_r;
        9'h040:  b_bus_s = cpp_r;
        9'h080:  b_bus_s = tos_r;
        9'h100:  b_bus_s = opc_r;
        default: b_bus_s = ZERO_W;
      endcase
    end else begin
      b_bus_s = ZERO_W;
    end
  end

  assign b_bus   = b_bus_s;
  assign sel_err = ~sel_valid_s;

  // Pure C-bus registers: H, OPC, TOS, CPP, LV, SP, PC, MAR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_r   <= ZERO_W;
      opc_r <= ZERO_W;
      tos_r <= ZERO_W;
      cpp_r <= CPP_INIT;
      lv_r  <= LV_INIT;
      sp_r  <= SP_INIT;
      pc_r  <= PC_INIT;
      mar_r <= ZERO_W;
    end else begin
      if (c_en[C_H])   h_r   <= c_bus;
      if (c_en[C_OPC]) opc_r <= c_bus;
      if (c_en[C_TOS]) tos_r <= c_bus;
      if (c_en[C_CPP]) cpp_r <= c_bus;
      if (c_en[C_LV])  lv_r  <= c_bus;
      if (c_en[C_SP])  sp_r  <= c_bus;
      if (c_en[C_PC])  pc_r  <= c_bus;
      if (c_en[C_MAR]) mar_r <= c_bus;
    end
  end

  // MDR: a pending memory read wins over a C-bus write in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdr_r <= ZERO_W;
    end else if (rd_pend_r) begin
      mdr_r <= mem_rdata;
    end else if (c_en[C_MDR]) begin
      mdr_r <= c_bus;
    end
  end

  // MBR: loaded only by a pending instruction fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mbr_r <= 8'h00;
    end else if (fetch_pend_r) begin
      mbr_r <= ifetch_data;
    end
  end

  // Request strobes and error pulse, one cycle after the MIR bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend_r    <= 1'b0;
      wr_req_r     <= 1'b0;
      fetch_pend_r <= 1'b0;
      mem_err_r    <= 1'b0;
    end else begin
      rd_pend_r    <= rd_ok_s;
      wr_req_r     <= wr_ok_s;
      fetch_pend_r <= mem_fetch;
      mem_err_r    <= rw_err_s;
    end
  end

  assign h_out         = h_r;
  assign mbr_out       = mbr_r;
  assign mar_addr      = mar_r;
  assign mdr_wdata     = mdr_r;
  assign pc_addr       = pc_r;
  assign mem_rd_req    = rd_pend_r;
  assign mem_wr_req    = wr_req_r;
  assign mem_fetch_req = fetch_pend_r;
  assign mem_err       = mem_err_r;

endmodule

// File: tb/tb_mic1_bbus_regfile.sv
// Directed testbench for mic1_bbus_regfile.
// Inputs change 2 ns after each rising edge; outputs are checked mid-cycle.
module tb_mic1_bbus_regfile;

  logic        clk;
  logic        rst_n;
  logic [15:0] b_sel;
  logic [8:0]  c_en;
  logic [31:0] c_bus;
  logic        mem_rd;
  logic        mem_wr;
  logic        mem_fetch;
  logic [31:0] mem_rdata;
  logic [7:0]  ifetch_data;
  logic [31:0] b_bus;
  logic [31:0] h_out;
  logic [7:0]  mbr_out;
  logic [31:0] mar_addr;
  logic [31:0] mdr_wdata;
  logic [31:0] pc_addr;
  logic        mem_rd_req;
  logic        mem_wr_req;
  logic        mem_fetch_req;
  logic        sel_err;
  logic        mem_err;

  int n_checks = 0;
  int n_fail   = 0;

  mic1_bbus_regfile dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .b_sel         (b_sel),
    .c_en          (c_en),
    .c_bus         (c_bus),
    .mem_rd        (mem_rd),
    .mem_wr        (mem_wr),
    .mem_fetch     (mem_fetch),
    .mem_rdata     (mem_rdata),
    .ifetch_data   (ifetch_data),
    .b_bus         (b_bus),
    .h_out         (h_out),
    .mbr_out       (mbr_out),
    .mar_addr      (mar_addr),
    .mdr_wdata     (mdr_wdata),
    .pc_addr       (pc_addr),
    .mem_rd_req    (mem_rd_req),
    .mem_wr_req    (mem_wr_req),
    .mem_fetch_req (mem_fetch_req),
    .sel_err       (sel_err),
    .mem_err       (mem_err)
  );

  // 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic bchk(input string tag, input logic [15:0] sel, input logic [31:0] exp);
    b_sel = sel;
    #1;
    check(tag, b_bus, exp);
  endtask

  task automatic idle;
    c_en      = 9'd0;
    c_bus     = 32'd0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_fetch = 1'b0;
  endtask

  initial begin
    rst_n       = 1'b0;
    b_sel       = 16'h0000;
    mem_rdata   = 32'd0;
    ifetch_data = 8'h00;
    idle();
    #12 rst_n = 1'b1;
    tick();

    // Reset values
    check("rst_pc", pc_addr, 32'h0000_0000);
    check("rst_h", h_out, 32'h0);
    check("rst_mar", mar_addr, 32'h0);
    check("rst_mdr", mdr_wdata, 32'h0);
    check("rst_mbr", {24'd0, mbr_out}, 32'h0);
    check("rst_reqs", {29'd0, mem_rd_req, mem_wr_req, mem_fetch_req}, 32'h0);
    check("rst_err", {31'd0, mem_err}, 32'h0);
    bchk("rst_sp", 16'h0010, 32'h0000_8000);
    bchk("rst_lv", 16'h0020, 32'h0000_8000);
    bchk("rst_cpp", 16'h0040, 32'h0000_4000);

    // Fetch with a PC write in the same cycle, byte F3
    c_en = 9'h004; c_bus = 32'h100; mem_fetch = 1'b1;
    tick();
    idle(); ifetch_data = 8'hF3;
    check("fetch_req", {31'd0, mem_fetch_req}, 32'h1);
    check("fetch_pc", pc_addr, 32'h100);
    tick();
    check("fetch_req_end", {31'd0, mem_fetch_req}, 32'h0);
    check("mbr_raw", {24'd0, mbr_out}, 32'h0000_00F3);
    bchk("mbr_sext", 16'h0004, 32'hFFFF_FFF3);
    bchk("mbru_zext", 16'h0008, 32'h0000_00F3);
    bchk("pc_bbus", 16'h0002, 32'h100);

    // Read with a MAR write in the same cycle
    c_en = 9'h001; c_bus = 32'h10; mem_rd = 1'b1;
    tick();
    idle(); mem_rdata = 32'hDEAD_BEEF;
    check("rd_req", {31'd0, mem_rd_req}, 32'h1);
    check("rd_mar", mar_addr, 32'h10);
    bchk("rd_mdr_early", 16'h0001, 32'h0);
    tick();
    check("rd_req_end", {31'd0, mem_rd_req}, 32'h0);
    bchk("rd_mdr", 16'h0001, 32'hDEAD_BEEF);

    // Read where a C write to MDR collides with the memory load
    mem_rd = 1'b1;
    tick();
    idle(); c_en = 9'h002; c_bus = 32'h1; mem_rdata = 32'h1234_5678;
    check("rdc_req", {31'd0, mem_rd_req}, 32'h1);
    tick();
    idle();
    check("rdc_mdr_prio", mdr_wdata, 32'h1234_5678);

    // Back-to-back reads
    mem_rd = 1'b1;
    tick();
    mem_rd = 1'b1; mem_rdata = 32'hA1A1_A1A1;
    check("b2b_req1", {31'd0, mem_rd_req}, 32'h1);
    tick();
    idle(); mem_rdata = 32'hA2A2_A2A2;
    check("b2b_req2", {31'd0, mem_rd_req}, 32'h1);
    check("b2b_mdr1", mdr_wdata, 32'hA1A1_A1A1);
    tick();
    check("b2b_req3", {31'd0, mem_rd_req}, 32'h0);
    check("b2b_mdr2", mdr_wdata, 32'hA2A2_A2A2);

    // Write: MAR then MDR with mem_wr
    c_en = 9'h001; c_bus = 32'h5;
    tick();
    c_en = 9'h002; c_bus = 32'hCAFE; mem_wr = 1'b1; mem_rdata = 32'h9999_9999;
    tick();
    idle();
    check("wr_req", {31'd0, mem_wr_req}, 32'h1);
    check("wr_rdreq", {31'd0, mem_rd_req}, 32'h0);
    check("wr_mar", mar_addr, 32'h5);
    check("wr_mdr", mdr_wdata, 32'hCAFE);
    tick();
    check("wr_req_end", {31'd0, mem_wr_req}, 32'h0);
    check("wr_mdr_hold", mdr_wdata, 32'hCAFE);

    // Multiple C enables at once
    c_en = 9'h1F8; c_bus = 32'h77;
    tick();
    idle();
    check("multi_h", h_out, 32'h77);
    bchk("multi_opc", 16'h0100, 32'h77);
    bchk("multi_tos", 16'h0080, 32'h77);
    bchk("multi_sp", 16'h0010, 32'h77);
    check("multi_pc_hold", pc_addr, 32'h100);

    // Invalid selects
    bchk("bad_hi_bus", 16'h0200, 32'h0);
    check("bad_hi_err", {31'd0, sel_err}, 32'h1);
    bchk("bad_multi_bus", 16'h0011, 32'h0);
    check("bad_multi_err", {31'd0, sel_err}, 32'h1);
    bchk("bad_zero_bus", 16'h0000, 32'h0);
    check("bad_zero_err", {31'd0, sel_err}, 32'h1);
    bchk("good_sel_bus", 16'h0040, 32'h77);
    check("good_sel_err", {31'd0, sel_err}, 32'h0);

    // Read and write together, with a fetch
    mem_rd = 1'b1; mem_wr = 1'b1; mem_fetch = 1'b1;
    tick();
    idle();
    check("rw_rdreq", {31'd0, mem_rd_req}, 32'h0);
    check("rw_wrreq", {31'd0, mem_wr_req}, 32'h0);
    check("rw_err", {31'd0, mem_err}, 32'h1);
    check("rw_fetch", {31'd0, mem_fetch_req}, 32'h1);
    tick();
    check("rw_err_end", {31'd0, mem_err}, 32'h0);

    // Reset in the middle of a pending read
    mem_rd = 1'b1; mem_rdata = 32'h5555_5555;
    tick();
    idle();
    check("rrst_req", {31'd0, mem_rd_req}, 32'h1);
    #1 rst_n = 1'b0;
    #1;
    check("rrst_async_req", {31'd0, mem_rd_req}, 32'h0);
    check("rrst_async_mdr", mdr_wdata, 32'h0);
    check("rrst_async_pc", pc_addr, 32'h0);
    bchk("rrst_async_sp", 16'h0010, 32'h0000_8000);
    bchk("rrst_async_cpp", 16'h0040, 32'h0000_4000);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    check("rrst_mdr_after", mdr_wdata, 32'h0);
    check("rrst_req_after", {31'd0, mem_rd_req}, 32'h0);
    tick();
    check("rrst_mdr_later", mdr_wdata, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mic1_bbus_regfile.md
Name: mic1_bbus_regfile

Overview:
- MIC-1 datapath register file, directly downstream of the 4-to-16 B-bus select decoder.
- Consumes the decoder's one-hot 16-bit select and drives the selected register onto the B bus.
- Latches the shifter output (C bus) into the registers enabled by the 9-bit C field.
- Owns the MAR/MDR/PC/MBR memory-port timing: read, write and fetch requests.

Parameters:
DATA_W, 32, datapath width
PC_INIT, 32'h0000_0000, PC reset value
SP_INIT, 32'h0000_8000, SP reset value
LV_INIT, 32'h0000_8000, LV reset value
CPP_INIT, 32'h0000_4000, CPP reset value

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
b_sel  in  16  one-hot B select from decoder: bit0 MDR, 1 PC, 2 MBR (signed), 3 MBRU, 4 SP, 5 LV, 6 CPP, 7 TOS, 8 OPC; bits 9-15 unused
c_en  in  9  C write enables: bit8 H, 7 OPC, 6 TOS, 5 CPP, 4 LV, 3 SP, 2 PC, 1 MDR, 0 MAR
c_bus  in  DATA_W  shifter result
mem_rd  in  1  MIR read bit
mem_wr  in  1  MIR write bit
mem_fetch  in  1  MIR fetch bit
mem_rdata  in  DATA_W  data-memory read data
ifetch_data  in  8  instruction byte from method area
b_bus  out  DATA_W  B bus to ALU
h_out  out  DATA_W  H register, ALU A input
mbr_out  out  8  raw MBR, for JMPC
mar_addr  out  DATA_W  MAR, word address
mdr_wdata  out  DATA_W  MDR, write data
pc_addr  out  DATA_W  PC, byte address
mem_rd_req  out  1  data read strobe
mem_wr_req  out  1  data write strobe
mem_fetch_req  out  1  instruction fetch strobe
sel_err  out  1  b_sel invalid (combinational)
mem_err  out  1  rd and wr in the same cycle (registered, one-cycle pulse)

Behaviour:
- Reset:
  - Async assert on rst_n low.
  - PC=PC_INIT, SP=SP_INIT, LV=LV_INIT, CPP=CPP_INIT.
  - H, OPC, TOS, MAR, MDR, MBR = 0.
  - mem_rd_req, mem_wr_req, mem_fetch_req, mem_err = 0.
  - Reset mid-transaction discards any pending read or fetch; the load never occurs after release.
- B bus (combinational, zero latency):
  - MBR sel: b_bus = sign-extended MBR.
  - MBRU sel: b_bus = zero-extended MBR.
  - b_sel zero, multi-hot, or any of bits 9-15 set: b_bus = 0 and sel_err = 1.
- C writes:
  - On a rising clk edge, every register with c_en bit set loads c_bus; multiple enables are legal.
  - h_out and the address/data outputs reflect new values from the next cycle.
- Read:
  - mem_rd=1 in cycle k: mem_rd_req=1 for exactly cycle k+1.
  - mar_addr in k+1 includes any MAR write from cycle k.
  - MDR loads mem_rdata at the end of k+1 and is readable on b_bus in k+2.
  - In k+1 the memory load has priority over c_en[1]; the C write to MDR is dropped.
- Write:
  - mem_wr=1 in cycle k: mem_wr_req=1 for cycle k+1.
  - mar_addr and mdr_wdata in k+1 include writes from cycle k.
- Fetch:
  - mem_fetch=1 in cycle k: mem_fetch_req=1 in k+1, with pc_addr including any PC write from k.
  - MBR loads ifetch_data at the end of k+1.
  - Fetch is independent of rd/wr; fetch with rd or with wr is legal.
- Back-to-back:
  - rd in k and rd in k+1 gives mem_rd_req high in k+1 and k+2, with two MDR loads.
  - Pending loads are tracked by one-deep pipeline flags; no queuing beyond that.
- Error:
  - mem_rd and mem_wr both 1 in cycle k: neither request issues, and mem_err=1 in k+1 only.
  - A fetch in the same cycle still issues.
- No internal FSM beyond the request/load flags. All register outputs are driven from flops, with no combinational path from inputs.

Test Plan:
- Reset: rst_n low mid-cycle -> PC=0, SP=32'h8000, CPP=32'h4000, all req=0 asynchronously; b_sel=16'h0010 -> b_bus=32'h8000.
- MBR extension: ifetch_data=8'hF3 fetched -> b_sel=bit2 gives b_bus=32'hFFFF_FFF3; b_sel=bit3 gives 32'h0000_00F3.
- Read timing: cycle k c_en=MAR, c_bus=32'h10, mem_rd=1 -> k+1 mem_rd_req=1 with mar_addr=32'h10; mem_rdata=32'hDEAD_BEEF -> b_sel=bit0 in k+2 gives 32'hDEAD_BEEF. Same sequence with c_en=MDR, c_bus=32'h1 in k+1 -> MDR still 32'hDEAD_BEEF.
- Write: MAR=5, MDR=32'hCAFE, mem_wr=1 -> next cycle mem_wr_req=1, mar_addr=5, mdr_wdata=32'hCAFE; no MDR change.
- Invalid select: b_sel=16'h0200, then 16'h0011, then 0 -> b_bus=0 and sel_err=1 each time; mem_rd=mem_wr=1 -> no reqs, mem_err pulse of exactly one cycle.
- Reset during read: mem_rd in k, rst_n low in k+1 -> MDR=0 after release, mem_rd_req=0.
